// File: rtl/cpu_pkg.sv
// Shared types and decode logic for the 16-bit accumulator CPU front end.
// The decode function is also used by the disassembler model.
package cpu_pkg;

   typedef enum logic [4:0] {
      OP_NOP, OP_HALT, OP_TRAP, OP_DROP, OP_PUSH, OP_POP, OP_RETURN, OP_NOT,
      OP_OUT_LO, OP_OUT_HI, OP_SET_DP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_BRANCH, OP_CALL, OP_IF, OP_ILLEGAL
   } op_t;

   typedef enum logic [2:0] {
      SRC_NONE, SRC_IMM, SRC_RAM_DP, SRC_RAM_SP, SRC_IND_DP, SRC_IND_SP, SRC_ACCUM
   } src_t;

   typedef enum logic [1:0] {COND_Z, COND_NZ, COND_ELSE, COND_NELSE} cond_t;

   typedef enum logic [1:0] {S_OP, S_ARG, S_DATA, S_HOLD} fd_state_t;

   localparam logic [7:0]  B0_LAST_SIMPLE = 8'h0A;
   localparam logic [7:0]  B0_LOAD_ACCUM  = 8'h44;

   localparam logic [4:0]  OPC_LOAD   = 5'b10000;
   localparam logic [4:0]  OPC_ADD    = 5'b10001;
   localparam logic [4:0]  OPC_STORE  = 5'b10010;
   localparam logic [4:0]  OPC_SUB    = 5'b10011;
   localparam logic [4:0]  OPC_AND    = 5'b10100;
   localparam logic [4:0]  OPC_OR     = 5'b10101;
   localparam logic [4:0]  OPC_XOR    = 5'b10110;
   localparam logic [4:0]  OPC_BRANCH = 5'b11000;
   localparam logic [4:0]  OPC_CALL   = 5'b11010;
   localparam logic [4:0]  OPC_IF     = 5'b11110;

   // IF argument may only use bits 4 and 0 (values 000, 001, 010, 011 hex)
   localparam logic [10:0] IF_ARG_MASK = 11'h7EE;

   // rhs is carried as 16 bits plus a flag; the consumer extends it to its width
   typedef struct packed {
      op_t         op;
      src_t        src;
      cond_t       cond;
      logic [15:0] rhs;
      logic        rhs_sext;
      logic [1:0]  len;
   } dec_t;

   // One-arg class with a data-byte source: instruction is three bytes long
   function automatic logic needs_data(input logic [7:0] b0);
      return (b0[7:6] == 2'b10) && (b0[2:1] == 2'b01);
   endfunction

   function automatic dec_t decode_ins(input logic [7:0] b0,
                                       input logic [7:0] b1,
                                       input logic [7:0] d);
      dec_t        r;
      logic [15:0] ins;
      logic        one_arg;
      ins        = {b0, b1};
      one_arg    = 1'b0;
      r.op       = OP_ILLEGAL;
      r.src      = SRC_NONE;
      r.cond     = COND_Z;
      r.rhs      = '0;
      r.rhs_sext = 1'b0;
      r.len      = 2'd2;
      if (!b0[7]) begin
         r.len = 2'd1;
         if (b0 <= B0_LAST_SIMPLE) begin
            r.op = op_t'(b0[4:0]);
         end else if (b0 == B0_LOAD_ACCUM) begin
            r.op  = OP_LOAD;
            r.src = SRC_ACCUM;
         end
      end else begin
         if (needs_data(b0)) r.len = 2'd3;
         case (ins[15:11])
            OPC_LOAD:  begin r.op = OP_LOAD;  one_arg = 1'b1; end
            OPC_ADD:   begin r.op = OP_ADD;   one_arg = 1'b1; end
            OPC_STORE: begin r.op = OP_STORE; one_arg = 1'b1; end
            OPC_SUB:   begin r.op = OP_SUB;   one_arg = 1'b1; end
            OPC_AND:   begin r.op = OP_AND;   one_arg = 1'b1; end
            OPC_OR:    begin r.op = OP_OR;    one_arg = 1'b1; end
            OPC_XOR:   begin r.op = OP_XOR;   one_arg = 1'b1; end
            OPC_BRANCH, OPC_CALL: begin
               r.op       = (ins[12]) ? OP_CALL : OP_BRANCH;
               r.rhs      = {{5{ins[10]}}, ins[10:0]};
               r.rhs_sext = 1'b1;
            end
            OPC_IF: begin
               if ((ins[10:0] & IF_ARG_MASK) == '0) begin
                  r.op   = OP_IF;
                  r.cond = cond_t'({ins[4], ins[0]});
               end
            end
            default: ;
         endcase
         if (one_arg) begin
            casez (ins[10:8])
               3'b00?: begin
                  r.src = SRC_IMM;
                  r.rhs = ins[8] ? {ins[7:0], 8'h00} : {8'h00, ins[7:0]};
               end
               3'b01?: begin
                  r.src = SRC_IMM;
                  r.rhs = ins[8] ? {d, 8'h00} : {8'h00, d};
               end
               3'b1?0: begin
                  r.src = ins[9] ? SRC_RAM_SP : SRC_RAM_DP;
                  r.rhs = {8'h00, ins[7:0]};
               end
               default: begin
                  r.src = ins[9] ? SRC_IND_SP : SRC_IND_DP;
                  r.rhs = {8'h00, ins[7:0]};
               end
            endcase
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide prefetch queue with count-based full/empty and synchronous clear.
// Head byte is presented combinationally (show-ahead).
module byte_fifo #(
   parameter int unsigned QDEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic [7:0] wdata_i,
   input  logic       pop_i,
   output logic [7:0] rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PW = $clog2(QDEPTH);

   logic [7:0]  mem_q [QDEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (PW+1)'(QDEPTH));
   assign empty_o = (cnt_q == '0);
   // push is refused while full even when a pop happens the same cycle
   assign do_push = push_i && !full_o && !clr_i;
   assign do_pop  = pop_i && !empty_o && !clr_i;
   assign rdata_o = mem_q[rd_q];

   // Storage array, written on accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

   // Pointers and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode stage: buffers program bytes, assembles 1-3 byte
// instructions and presents one registered decoded instruction per transfer.
module fetch_decode_unit #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned QDEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        fetch_data,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [4:0]        dec_op,
   output logic [2:0]        dec_src,
   output logic [1:0]        dec_cond,
   output logic [WIDTH-1:0]  dec_rhs,
   output logic [1:0]        dec_len,
   output logic [ADDR_W-1:0] dec_pc
);
   import cpu_pkg::*;

   fd_state_t         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d;
   op_t               op_q, op_d;
   src_t              src_q, src_d;
   cond_t             cond_q, cond_d;
   logic [WIDTH-1:0]  rhs_q, rhs_d;
   logic [1:0]        len_q, len_d;
   logic [ADDR_W-1:0] dpc_q, dpc_d;

   logic [7:0]        q_head;
   logic              q_full, q_empty, q_pop, q_push;
   logic              load_out;
   logic [7:0]        in_b0, in_b1, in_d;
   dec_t              dcur;
   logic [WIDTH-1:0]  rhs_ext;

   assign fetch_ready = !q_full;
   assign q_push      = fetch_valid && !q_full;

   byte_fifo #(.QDEPTH(QDEPTH)) u_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (flush),
      .push_i  (q_push),
      .wdata_i (fetch_data),
      .pop_i   (q_pop),
      .rdata_o (q_head),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   assign dec_valid = (state_q == S_HOLD);
   assign dec_op    = op_q;
   assign dec_src   = src_q;
   assign dec_cond  = cond_q;
   assign dec_rhs   = rhs_q;
   assign dec_len   = len_q;
   assign dec_pc    = dpc_q;

   // Next-state, byte collection, decode and output-register load
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      op_d     = op_q;
      src_d    = src_q;
      cond_d   = cond_q;
      rhs_d    = rhs_q;
      len_d    = len_q;
      dpc_d    = dpc_q;
      q_pop    = 1'b0;
      load_out = 1'b0;
      in_b0    = b0_q;
      in_b1    = b1_q;
      in_d     = q_head;

      unique case (state_q)
         S_OP: begin
            if (!q_empty) begin
               q_pop = 1'b1;
               b0_d  = q_head;
               dpc_d = pc_q;
               in_b0 = q_head;
               if (!q_head[7]) begin
                  load_out = 1'b1;
                  state_d  = S_HOLD;
               end else begin
                  state_d  = S_ARG;
               end
            end
         end
         S_ARG: begin
            if (!q_empty) begin
               q_pop = 1'b1;
               b1_d  = q_head;
               in_b1 = q_head;
               if (needs_data(b0_q)) begin
                  state_d  = S_DATA;
               end else begin
                  load_out = 1'b1;
                  state_d  = S_HOLD;
               end
            end
         end
         S_DATA: begin
            if (!q_empty) begin
               q_pop    = 1'b1;
               load_out = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (dec_ready) state_d = S_OP;
         end
         default: state_d = S_OP;
      endcase

      if (q_pop) pc_d = pc_q + ADDR_W'(1);

      // flush discards any partial or held instruction and redirects the PC
      if (flush) begin
         state_d  = S_OP;
         pc_d     = flush_pc;
         q_pop    = 1'b0;
         load_out = 1'b0;
         b0_d     = b0_q;
         b1_d     = b1_q;
         dpc_d    = dpc_q;
      end

      dcur    = decode_ins(in_b0, in_b1, in_d);
      rhs_ext = WIDTH'(dcur.rhs);
      if (dcur.rhs_sext) begin
         for (int unsigned i = 16; i < WIDTH; i++) rhs_ext[i] = dcur.rhs[15];
      end

      if (load_out) begin
         op_d   = dcur.op;
         src_d  = dcur.src;
         cond_d = dcur.cond;
         rhs_d  = rhs_ext;
         len_d  = dcur.len;
      end
   end

   // State, PC, collected bytes and decoded output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OP;
         pc_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         op_q    <= OP_NOP;
         src_q   <= SRC_NONE;
         cond_q  <= COND_Z;
         rhs_q   <= '0;
         len_q   <= '0;
         dpc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         op_q    <= op_d;
         src_q   <= src_d;
         cond_q  <= cond_d;
         rhs_q   <= rhs_d;
         len_q   <= len_d;
         dpc_q   <= dpc_d;
      end
   end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit (WIDTH=24, QDEPTH=4).
module tb_fetch_decode_unit;
   import cpu_pkg::*;

   localparam int unsigned WIDTH  = 24;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned QDEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        fetch_data;
   logic              fetch_valid;
   logic              fetch_ready;
   logic              flush = 1'b0;
   logic [ADDR_W-1:0] flush_pc = '0;
   logic              dec_valid;
   logic              dec_ready = 1'b0;
   logic [4:0]        dec_op;
   logic [2:0]        dec_src;
   logic [1:0]        dec_cond;
   logic [WIDTH-1:0]  dec_rhs;
   logic [1:0]        dec_len;
   logic [ADDR_W-1:0] dec_pc;

   int unsigned checks = 0;
   int unsigned passes = 0;

   logic [7:0]  txq[$];
   logic [51:0] rxq[$];
   logic [51:0] obs;

   assign obs = {dec_op, dec_src, dec_cond, dec_rhs, dec_len, dec_pc};

   always #5 clk = ~clk;

   fetch_decode_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_data  (fetch_data),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_op      (dec_op),
      .dec_src     (dec_src),
      .dec_cond    (dec_cond),
      .dec_rhs     (dec_rhs),
      .dec_len     (dec_len),
      .dec_pc      (dec_pc)
   );

   function automatic logic [51:0] pk(input logic [4:0] op, input logic [2:0] src,
                                      input logic [1:0] cond, input logic [23:0] rhs,
                                      input logic [1:0] len, input logic [15:0] pc);
      return {op, src, cond, rhs, len, pc};
   endfunction

   // byte source: presents the head of txq; a byte is consumed when fetch_ready
   initial begin
      fetch_valid = 1'b0;
      fetch_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (txq.size() > 0 && rst_n) begin
            fetch_valid = 1'b1;
            fetch_data  = txq[0];
            if (fetch_ready) void'(txq.pop_front());
         end else begin
            fetch_valid = 1'b0;
         end
      end
   end

   // transfer monitor
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && dec_valid && dec_ready) rxq.push_back(obs);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      dec_ready = 1'b0;
      flush     = 1'b0;
      txq.delete();
      cyc(2);
      rxq.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rxq.size() < n; i++) @(negedge clk);
      cyc(1);
   endtask

   task automatic test_reset();
      logic [51:0] got;
      #3;
      checks++;
      if (obs !== '0 || dec_valid !== 1'b0)
         $display("FAIL reset_outputs: got %h valid %b expected 0 valid 0", obs, dec_valid);
      else passes++;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      checks++;
      if (fetch_ready !== 1'b1) $display("FAIL reset_fetch_ready: got %b expected 1", fetch_ready);
      else passes++;
      got = {dec_valid, 51'd0};
      checks++;
      if (got !== 52'd0) $display("FAIL reset_dec_valid: got %b expected 0", dec_valid);
      else passes++;
   endtask

   task automatic test_simple_ops();
      logic [51:0] exp[3];
      logic [51:0] got;
      apply_reset();
      dec_ready = 1'b1;
      exp[0] = pk(OP_NOP,    SRC_NONE, COND_Z, 24'h0, 2'd1, 16'd0);
      exp[1] = pk(OP_HALT,   SRC_NONE, COND_Z, 24'h0, 2'd1, 16'd1);
      exp[2] = pk(OP_SET_DP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'd2);
      txq = '{8'h00, 8'h01, 8'h0A};
      wait_rx(3, 40);
      checks++;
      if (rxq.size() != 3) $display("FAIL simple_count: got %0d expected 3", rxq.size());
      else passes++;
      for (int i = 0; i < 3; i++) begin
         got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
         checks++;
         if (got !== exp[i]) $display("FAIL simple_%0d: got %h expected %h", i, got, exp[i]);
         else passes++;
      end
   endtask

   task automatic test_load_add();
      logic [51:0] exp[2];
      logic [51:0] got;
      apply_reset();
      dec_ready = 1'b1;
      exp[0] = pk(OP_LOAD, SRC_IMM, COND_Z, 24'h003400, 2'd2, 16'd0);
      exp[1] = pk(OP_ADD,  SRC_IMM, COND_Z, 24'h000099, 2'd3, 16'd2);
      txq = '{8'h81, 8'h34, 8'h8A, 8'h12, 8'h99};
      wait_rx(2, 40);
      checks++;
      if (rxq.size() != 2) $display("FAIL load_add_count: got %0d expected 2", rxq.size());
      else passes++;
      for (int i = 0; i < 2; i++) begin
         got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
         checks++;
         if (got !== exp[i]) $display("FAIL load_add_%0d: got %h expected %h", i, got, exp[i]);
         else passes++;
      end
   endtask

   task automatic test_branch_if();
      logic [51:0] exp[3];
      logic [51:0] got;
      apply_reset();
      dec_ready = 1'b1;
      exp[0] = pk(OP_BRANCH,  SRC_NONE, COND_Z,     24'hFFFFFF, 2'd2, 16'd0);
      exp[1] = pk(OP_IF,      SRC_NONE, COND_NELSE, 24'h000000, 2'd2, 16'd2);
      exp[2] = pk(OP_ILLEGAL, SRC_NONE, COND_Z,     24'h000000, 2'd2, 16'd4);
      txq = '{8'hC7, 8'hFF, 8'hF0, 8'h11, 8'hF0, 8'h02};
      wait_rx(3, 50);
      checks++;
      if (rxq.size() != 3) $display("FAIL branch_if_count: got %0d expected 3", rxq.size());
      else passes++;
      for (int i = 0; i < 3; i++) begin
         got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
         checks++;
         if (got !== exp[i]) $display("FAIL branch_if_%0d: got %h expected %h", i, got, exp[i]);
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [51:0] got;
      logic [51:0] exp0;
      apply_reset();
      dec_ready = 1'b0;
      exp0 = pk(OP_NOP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'd0);
      txq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      cyc(12);
      checks++;
      if (fetch_ready !== 1'b0) $display("FAIL bp_full: got fetch_ready %b expected 0", fetch_ready);
      else passes++;
      checks++;
      if (txq.size() != 1) $display("FAIL bp_pending: got %0d bytes waiting expected 1", txq.size());
      else passes++;
      checks++;
      if (dec_valid !== 1'b1 || obs !== exp0)
         $display("FAIL bp_hold: got valid %b %h expected valid 1 %h", dec_valid, obs, exp0);
      else passes++;
      cyc(5);
      checks++;
      if (dec_valid !== 1'b1 || obs !== exp0)
         $display("FAIL bp_stable: got valid %b %h expected valid 1 %h", dec_valid, obs, exp0);
      else passes++;
      checks++;
      if (rxq.size() != 0) $display("FAIL bp_no_xfer: got %0d expected 0", rxq.size());
      else passes++;
      dec_ready = 1'b1;
      wait_rx(6, 60);
      checks++;
      if (rxq.size() != 6) $display("FAIL bp_count: got %0d expected 6", rxq.size());
      else passes++;
      for (int i = 0; i < 6; i++) begin
         got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
         checks++;
         if (got !== pk(5'(i), SRC_NONE, COND_Z, 24'h0, 2'd1, 16'(i)))
            $display("FAIL bp_order_%0d: got %h expected %h", i, got,
                     pk(5'(i), SRC_NONE, COND_Z, 24'h0, 2'd1, 16'(i)));
         else passes++;
      end
   endtask

   task automatic test_flush();
      logic [51:0] got;
      logic [51:0] exp;
      apply_reset();
      dec_ready = 1'b1;
      txq = '{8'h81};
      cyc(5);
      checks++;
      if (dec_valid !== 1'b0) $display("FAIL flush_partial: got valid %b expected 0", dec_valid);
      else passes++;
      flush    = 1'b1;
      flush_pc = 16'h0100;
      cyc(1);
      flush = 1'b0;
      txq = '{8'h02};
      wait_rx(1, 30);
      exp = pk(OP_TRAP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'h0100);
      checks++;
      if (rxq.size() != 1) $display("FAIL flush_count: got %0d expected 1", rxq.size());
      else passes++;
      got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
      checks++;
      if (got !== exp) $display("FAIL flush_trap: got %h expected %h", got, exp);
      else passes++;
      // PC wraps at the top of the address space
      flush    = 1'b1;
      flush_pc = 16'hFFFF;
      cyc(1);
      flush = 1'b0;
      rxq.delete();
      txq = '{8'h00, 8'h03};
      wait_rx(2, 30);
      checks++;
      got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
      exp = pk(OP_NOP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'hFFFF);
      if (got !== exp) $display("FAIL wrap_0: got %h expected %h", got, exp);
      else passes++;
      checks++;
      got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
      exp = pk(OP_DROP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'h0000);
      if (got !== exp) $display("FAIL wrap_1: got %h expected %h", got, exp);
      else passes++;
   endtask

   task automatic test_accum();
      logic [51:0] got;
      logic [51:0] exp;
      apply_reset();
      dec_ready = 1'b1;
      txq = '{8'h44};
      wait_rx(1, 30);
      exp = pk(OP_LOAD, SRC_ACCUM, COND_Z, 24'h0, 2'd1, 16'd0);
      got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
      checks++;
      if (got !== exp) $display("FAIL accum: got %h expected %h", got, exp);
      else passes++;
   endtask

   task automatic test_reset_mid();
      logic [51:0] got;
      logic [51:0] exp;
      apply_reset();
      dec_ready = 1'b1;
      txq = '{8'h81, 8'h34};
      wait_rx(1, 30);
      rxq.delete();
      txq = '{8'h8A, 8'h12};
      cyc(6);
      checks++;
      if (dec_valid !== 1'b0 || dec_op !== 5'(OP_LOAD))
         $display("FAIL mid_pre: got valid %b op %0d expected valid 0 op %0d", dec_valid, dec_op, OP_LOAD);
      else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== '0 || dec_valid !== 1'b0)
         $display("FAIL mid_async_reset: got %h valid %b expected 0 valid 0", obs, dec_valid);
      else passes++;
      cyc(2);
      rxq.delete();
      rst_n = 1'b1;
      txq = '{8'h02};
      wait_rx(1, 30);
      exp = pk(OP_TRAP, SRC_NONE, COND_Z, 24'h0, 2'd1, 16'd0);
      checks++;
      if (rxq.size() != 1) $display("FAIL mid_restart_count: got %0d expected 1", rxq.size());
      else passes++;
      got = (rxq.size() > 0) ? rxq.pop_front() : 'x;
      checks++;
      if (got !== exp) $display("FAIL mid_restart: got %h expected %h", got, exp);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_simple_ops();
      test_load_add();
      test_branch_if();
      test_backpressure();
      test_flush();
      test_accum();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
